ft600_chip_model: RTL and testbench
===================================

Name: ft600_chip_model

Overview:
- Synthesizable model of the FT600 chip side of the 245-mode FIFO bus.
- Responds to the FPGA-side bus master: drives ft_txe/ft_rxf, samples ft_oe/ft_rd/ft_wr, drives ft_data/ft_be while the master reads.
- Two word FIFOs:
  - down: host to FPGA, fed from host_tx_*.
  - up: FPGA to host, drained to host_rx_*.
- Used for on-chip loopback and as the bus responder in controller benches.

Parameters:
- DEPTH, 16, words per FIFO (power of two, at least 2).
- AW, $clog2(DEPTH), FIFO pointer width.

Ports:
- clk  in  1  single clock. Also fed to the master as its ft_clk.
- rst  in  1  synchronous reset, active-high.
- host_tx_valid  in  1  host offers a word for the down FIFO.
- host_tx_ready  out  1  down FIFO not full.
- host_tx_data  in  16  word; [15:8] is the first byte.
- host_tx_be  in  2  byte enables, 11 or 10 only.
- host_rx_valid  out  1  up FIFO not empty.
- host_rx_ready  in  1  host takes the head word.
- host_rx_data  out  16  head word of the up FIFO.
- host_rx_be  out  2  head byte enables.
- ft_data_i  in  16  bus data driven by the master.
- ft_be_i  in  2  bus byte enables driven by the master.
- ft_data_o  out  16  data the chip drives.
- ft_be_o  out  2  byte enables the chip drives.
- ft_drive  out  1  chip output enable for ft_data_o/ft_be_o; equals ~ft_oe.
- ft_txe  out  1  active-low: up FIFO has space.
- ft_rxf  out  1  active-low: down FIFO has data.
- ft_oe  in  1  active-low: master requests the chip to drive.
- ft_rd  in  1  active-low read strobe.
- ft_wr  in  1  active-low write strobe.
- err_underrun  out  1  sticky.
- err_overflow  out  1  sticky.
- err_contention  out  1  sticky.

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - Both FIFOs empty; all error flags 0.
  - ft_rxf=1, ft_txe=0, host_rx_valid=0, host_tx_ready=1.
- Status timing:
  - ft_rxf = (down_count==0) and ft_txe = (up_count==DEPTH), both decoded combinationally from registered counts.
  - A host push at edge N shows ft_rxf=0 after edge N, so the master sees it from edge N+1.
- Read path:
  - ft_data_o/ft_be_o present the down FIFO head combinationally (first-word-fall-through).
  - When the FIFO is empty: ft_data_o=0, ft_be_o=00.
  - Pop at a posedge when ft_oe=0 and ft_rd=0 and ft_rxf=0; one word per cycle, so back-to-back bursts are legal.
  - ft_rd=0 with ft_oe=1: no pop.
- Underrun: ft_oe=0 and ft_rd=0 while ft_rxf=1 sets err_underrun. No pop; pointers unchanged.
- Write path:
  - Push {ft_be_i, ft_data_i} at a posedge when ft_wr=0, ft_oe=1 and ft_txe=0.
  - be=00: word discarded, no push, no error.
  - be=01: pushed as-is.
- Overflow: ft_wr=0 while ft_txe=1 sets err_overflow. Word dropped.
- Contention: ft_wr=0 and ft_oe=0 in the same cycle sets err_contention. No push; a read may still pop.
- Simultaneous push and pop on one FIFO:
  - Both happen; count unchanged.
  - Allowed when full: the pop frees the slot, so host_tx_ready may be combinationally ~full | bus pop. host_tx_ready is ~full only, to avoid a combinational path from bus inputs.
  - Allowed when empty only for the up FIFO to host: not allowed. host_rx_valid is ~empty; no bypass.
- Wrap-around: pointers are AW bits wide and wrap modulo DEPTH. Count is AW+1 bits, range 0..DEPTH.
- Host handshakes:
  - Push on host_tx_valid & host_tx_ready.
  - Pop on host_rx_valid & host_rx_ready.
  - Data must hold while valid=1 and ready=0.
- Reset mid-burst: FIFO contents are discarded. Outputs return to reset values at the next edge, whatever the bus strobes are.
- Error flags are sticky until rst.

Decomposition:
- Package ft600_pkg holds:
  - ft_word_t struct {be[1:0], data[15:0]}.
  - Constants BE_BOTH=2'b11, BE_HI=2'b10, BE_NONE=2'b00.
- Sub-module ft600_word_fifo: synchronous first-word-fall-through FIFO of ft_word_t, parameter DEPTH. Ports: clk, rst, push, din, pop, dout, count, full, empty. Instanced twice (down, up).
- Top level holds strobe decode, error flags and tristate-enable logic only.

Test Plan:
- Reset sweep, then one host push of 16'hA55A be=11 -> ft_rxf=0 one edge later. With ft_oe=0 and ft_rd=0 held one cycle: ft_data_o=16'hA55A, pop occurs, then ft_rxf=1.
- Burst read: push 4 words 0x0001..0x0004, master holds ft_oe=0 and ft_rd=0 for 5 cycles -> 4 words out in order, err_underrun=1 on the fifth cycle, FIFO stays empty.
- Write fill: ft_oe=1, ft_wr=0 for DEPTH+1 cycles with incrementing data, be=11 -> ft_txe=1 after DEPTH pushes, err_overflow=1, host reads DEPTH words 0..DEPTH-1.
- Partial write: ft_wr=0 with be=10, data 16'h7F00 -> host_rx_be=10, data 16'h7F00. With be=00 -> no word, no error.
- Contention: ft_oe=0 and ft_wr=0 for one cycle with down FIFO non-empty -> err_contention=1, up FIFO count unchanged, down pop occurs only if ft_rd=0.
- Reset mid-burst: rst=1 during a 3-of-8 word read -> next cycle ft_rxf=1, ft_txe=0, all error flags 0, host_rx_valid=0.

Source files
------------

// File: rtl/ft600_pkg.sv
// Shared types and constants for the FT600 245-mode FIFO bus chip model.
package ft600_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } ft_word_t;

    localparam logic [BE_W-1:0] BE_BOTH = 2'b11;
    localparam logic [BE_W-1:0] BE_HI   = 2'b10;
    localparam logic [BE_W-1:0] BE_NONE = 2'b00;

endpackage

// File: rtl/ft600_word_fifo.sv
// Synchronous first-word-fall-through FIFO of bus words; head is visible on dout
// whenever the FIFO is non-empty.
module ft600_word_fifo
    import ft600_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  ft_word_t      din,
    input  logic          pop,
    output ft_word_t      dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    ft_word_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Requests against a full/empty FIFO are ignored rather than corrupting state.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ft600_chip_model.sv
// FT600 chip side of the 245-mode FIFO bus: host-fed down FIFO read by the bus
// master, bus-written up FIFO drained by the host, plus sticky protocol error flags.
module ft600_chip_model
    import ft600_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_tx_valid,
    output logic              host_tx_ready,
    input  logic [DATA_W-1:0] host_tx_data,
    input  logic [BE_W-1:0]   host_tx_be,
    output logic              host_rx_valid,
    input  logic              host_rx_ready,
    output logic [DATA_W-1:0] host_rx_data,
    output logic [BE_W-1:0]   host_rx_be,
    input  logic [DATA_W-1:0] ft_data_i,
    input  logic [BE_W-1:0]   ft_be_i,
    output logic [DATA_W-1:0] ft_data_o,
    output logic [BE_W-1:0]   ft_be_o,
    output logic              ft_drive,
    output logic              ft_txe,
    output logic              ft_rxf,
    input  logic              ft_oe,
    input  logic              ft_rd,
    input  logic              ft_wr,
    output logic              err_underrun,
    output logic              err_overflow,
    output logic              err_contention
);

    ft_word_t    down_din;
    ft_word_t    down_head;
    logic [AW:0] down_count;
    logic        down_full;
    logic        down_empty;
    logic        down_push;
    logic        down_pop;

    ft_word_t    up_din;
    ft_word_t    up_head;
    logic [AW:0] up_count;
    logic        up_full;
    logic        up_empty;
    logic        up_push;
    logic        up_pop;

    logic        bus_read;
    logic        bus_write;

    // Strobe decode (all strobes active-low)
    assign bus_read  = ~ft_oe & ~ft_rd;
    assign bus_write = ~ft_wr;

    assign down_din  = '{be: host_tx_be, data: host_tx_data};
    assign down_push = host_tx_valid & host_tx_ready;
    assign down_pop  = bus_read & ~down_empty;

    // A write while the chip is driving is contention and never lands; be=00 is a null write.
    assign up_din    = '{be: ft_be_i, data: ft_data_i};
    assign up_push   = bus_write & ft_oe & ~up_full & (ft_be_i != BE_NONE);
    assign up_pop    = host_rx_valid & host_rx_ready;

    ft600_word_fifo #(.DEPTH(DEPTH)) u_down (
        .clk   (clk),
        .rst   (rst),
        .push  (down_push),
        .din   (down_din),
        .pop   (down_pop),
        .dout  (down_head),
        .count (down_count),
        .full  (down_full),
        .empty (down_empty)
    );

    ft600_word_fifo #(.DEPTH(DEPTH)) u_up (
        .clk   (clk),
        .rst   (rst),
        .push  (up_push),
        .din   (up_din),
        .pop   (up_pop),
        .dout  (up_head),
        .count (up_count),
        .full  (up_full),
        .empty (up_empty)
    );

    assign ft_rxf        = (down_count == '0);
    assign ft_txe        = (up_count == (AW + 1)'(DEPTH));
    assign host_tx_ready = ~down_full;
    assign host_rx_valid = ~up_empty;
    assign host_rx_data  = up_head.data;
    assign host_rx_be    = up_head.be;

    // Idle bus reads as zero so an empty FIFO never exposes stale storage.
    assign ft_data_o = down_empty ? '0 : down_head.data;
    assign ft_be_o   = down_empty ? BE_NONE : down_head.be;
    assign ft_drive  = ~ft_oe;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_underrun   <= 1'b0;
            err_overflow   <= 1'b0;
            err_contention <= 1'b0;
        end else begin
            if (bus_read & ft_rxf)     err_underrun   <= 1'b1;
            if (bus_write & ft_txe)    err_overflow   <= 1'b1;
            if (bus_write & ~ft_oe)    err_contention <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ft600_chip_model.sv
// Self-checking bench for ft600_chip_model: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_ft600_chip_model;
    import ft600_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_tx_valid;
    logic        host_tx_ready;
    logic [15:0] host_tx_data;
    logic [1:0]  host_tx_be;
    logic        host_rx_valid;
    logic        host_rx_ready;
    logic [15:0] host_rx_data;
    logic [1:0]  host_rx_be;
    logic [15:0] ft_data_i;
    logic [1:0]  ft_be_i;
    logic [15:0] ft_data_o;
    logic [1:0]  ft_be_o;
    logic        ft_drive;
    logic        ft_txe;
    logic        ft_rxf;
    logic        ft_oe;
    logic        ft_rd;
    logic        ft_wr;
    logic        err_underrun;
    logic        err_overflow;
    logic        err_contention;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: plain queues of {be, data} plus sticky flags
    logic [17:0] down_q[$];
    logic [17:0] up_q[$];
    logic        m_und;
    logic        m_ovf;
    logic        m_con;

    always #5 clk = ~clk;

    ft600_chip_model #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .host_tx_valid  (host_tx_valid),
        .host_tx_ready  (host_tx_ready),
        .host_tx_data   (host_tx_data),
        .host_tx_be     (host_tx_be),
        .host_rx_valid  (host_rx_valid),
        .host_rx_ready  (host_rx_ready),
        .host_rx_data   (host_rx_data),
        .host_rx_be     (host_rx_be),
        .ft_data_i      (ft_data_i),
        .ft_be_i        (ft_be_i),
        .ft_data_o      (ft_data_o),
        .ft_be_o        (ft_be_o),
        .ft_drive       (ft_drive),
        .ft_txe         (ft_txe),
        .ft_rxf         (ft_rxf),
        .ft_oe          (ft_oe),
        .ft_rd          (ft_rd),
        .ft_wr          (ft_wr),
        .err_underrun   (err_underrun),
        .err_overflow   (err_overflow),
        .err_contention (err_contention)
    );

    typedef struct {
        logic        rst;
        logic        tx_v;
        logic [15:0] tx_d;
        logic [1:0]  tx_be;
        logic        oe;
        logic        rd;
        logic        wr;
        logic [1:0]  fbe;
        logic [15:0] fd;
        logic        rxr;
        logic        e_rxf;
        logic        e_txe;
        logic        e_rxv;
        logic [15:0] e_rxd;
        logic [1:0]  e_rxbe;
        logic [15:0] e_do;
        logic [1:0]  e_beo;
        logic        e_drive;
        logic [2:0]  e_err;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst           = 1'b0;
        host_tx_valid = 1'b0;
        host_tx_data  = 16'h0000;
        host_tx_be    = BE_BOTH;
        host_rx_ready = 1'b0;
        ft_data_i     = 16'h0000;
        ft_be_i       = BE_NONE;
        ft_oe         = 1'b1;
        ft_rd         = 1'b1;
        ft_wr         = 1'b1;
    endtask

    // Advance one clock and update the model from the inputs held across that edge.
    task automatic cycle();
        int unsigned dn;
        int unsigned un;
        logic        brd;
        logic        bwr;
        dn  = down_q.size();
        un  = up_q.size();
        brd = !ft_oe && !ft_rd;
        bwr = !ft_wr;
        @(posedge clk);
        #1;
        if (rst) begin
            down_q.delete();
            up_q.delete();
            m_und = 1'b0;
            m_ovf = 1'b0;
            m_con = 1'b0;
        end else begin
            if (brd && dn == 0)      m_und = 1'b1;
            if (bwr && !ft_oe)       m_con = 1'b1;
            if (bwr && un == DEPTH)  m_ovf = 1'b1;
            if (brd && dn > 0)             void'(down_q.pop_front());
            if (host_rx_ready && un > 0)   void'(up_q.pop_front());
            if (host_tx_valid && dn < DEPTH) down_q.push_back({host_tx_be, host_tx_data});
            if (bwr && ft_oe && un < DEPTH && ft_be_i != 2'b00) up_q.push_back({ft_be_i, ft_data_i});
        end
    endtask

    task automatic check_all(input string tag);
        logic [17:0] dh;
        logic [17:0] uh;
        dh = (down_q.size() > 0) ? down_q[0] : 18'h0;
        uh = (up_q.size() > 0) ? up_q[0] : 18'h0;
        chk({tag, ".ft_rxf"}, 32'(ft_rxf), 32'(down_q.size() == 0));
        chk({tag, ".ft_txe"}, 32'(ft_txe), 32'(up_q.size() == DEPTH));
        chk({tag, ".host_tx_ready"}, 32'(host_tx_ready), 32'(down_q.size() < DEPTH));
        chk({tag, ".host_rx_valid"}, 32'(host_rx_valid), 32'(up_q.size() > 0));
        if (up_q.size() > 0) begin
            chk({tag, ".host_rx_data"}, 32'(host_rx_data), 32'(uh[15:0]));
            chk({tag, ".host_rx_be"}, 32'(host_rx_be), 32'(uh[17:16]));
        end
        chk({tag, ".ft_data_o"}, 32'(ft_data_o), 32'(dh[15:0]));
        chk({tag, ".ft_be_o"}, 32'(ft_be_o), 32'(dh[17:16]));
        chk({tag, ".ft_drive"}, 32'(ft_drive), 32'(!ft_oe));
        chk({tag, ".errs"}, 32'({err_contention, err_overflow, err_underrun}), 32'({m_con, m_ovf, m_und}));
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        m_und = 1'b0;
        m_ovf = 1'b0;
        m_con = 1'b0;

        //              rst  txv  tx_d      txbe   oe   rd   wr   fbe    fd        rxr  | rxf txe rxv rxd      rxbe   do        beo    drv  err
        tbl[0] = '{1'b0, 1'b1, 16'hA55A, 2'b11, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'hA55A, 2'b11, 1'b0, 3'b000};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b1, 3'b000};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 16'h7F00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7F00, 2'b10, 16'h0000, 2'b00, 1'b0, 3'b000};
        tbl[3] = '{1'b0, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b0, 3'b000};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b1, 3'b001};
        tbl[5] = '{1'b0, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b1, 3'b101};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b0, 3'b000};
        tbl[7] = '{1'b0, 1'b1, 16'h1111, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h1111, 2'b10, 1'b0, 3'b000};
        tbl[8] = '{1'b0, 1'b1, 16'h2222, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h2222, 2'b11, 1'b1, 3'b000};

        // Reset state
        do_reset();
        chk("reset.ft_rxf", 32'(ft_rxf), 32'd1);
        chk("reset.ft_txe", 32'(ft_txe), 32'd0);
        chk("reset.host_rx_valid", 32'(host_rx_valid), 32'd0);
        chk("reset.host_tx_ready", 32'(host_tx_ready), 32'd1);
        chk("reset.errs", 32'({err_contention, err_overflow, err_underrun}), 32'd0);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            rst           = tbl[i].rst;
            host_tx_valid = tbl[i].tx_v;
            host_tx_data  = tbl[i].tx_d;
            host_tx_be    = tbl[i].tx_be;
            ft_oe         = tbl[i].oe;
            ft_rd         = tbl[i].rd;
            ft_wr         = tbl[i].wr;
            ft_be_i       = tbl[i].fbe;
            ft_data_i     = tbl[i].fd;
            host_rx_ready = tbl[i].rxr;
            cycle();
            chk($sformatf("vec%0d.ft_rxf", i), 32'(ft_rxf), 32'(tbl[i].e_rxf));
            chk($sformatf("vec%0d.ft_txe", i), 32'(ft_txe), 32'(tbl[i].e_txe));
            chk($sformatf("vec%0d.host_rx_valid", i), 32'(host_rx_valid), 32'(tbl[i].e_rxv));
            if (tbl[i].e_rxv) begin
                chk($sformatf("vec%0d.host_rx_data", i), 32'(host_rx_data), 32'(tbl[i].e_rxd));
                chk($sformatf("vec%0d.host_rx_be", i), 32'(host_rx_be), 32'(tbl[i].e_rxbe));
            end
            chk($sformatf("vec%0d.ft_data_o", i), 32'(ft_data_o), 32'(tbl[i].e_do));
            chk($sformatf("vec%0d.ft_be_o", i), 32'(ft_be_o), 32'(tbl[i].e_beo));
            chk($sformatf("vec%0d.ft_drive", i), 32'(ft_drive), 32'(tbl[i].e_drive));
            chk($sformatf("vec%0d.errs", i), 32'({err_contention, err_overflow, err_underrun}), 32'(tbl[i].e_err));
            check_all($sformatf("vec%0d", i));
        end

        // Burst read of four words, fifth strobe underruns
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            host_tx_valid = 1'b1;
            host_tx_data  = 16'(i);
            host_tx_be    = BE_BOTH;
            cycle();
        end
        idle();
        ft_oe = 1'b0;
        ft_rd = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) chk($sformatf("burst.word%0d", i), 32'(ft_data_o), 32'(i));
            cycle();
            check_all($sformatf("burst%0d", i));
            if (i == 4) chk("burst.no_underrun_yet", 32'(err_underrun), 32'd0);
        end
        chk("burst.underrun", 32'(err_underrun), 32'd1);
        chk("burst.empty", 32'(ft_rxf), 32'd1);

        // Fill the up FIFO past capacity, then drain from the host side
        do_reset();
        ft_wr   = 1'b0;
        ft_be_i = BE_BOTH;
        for (int i = 0; i <= DEPTH; i++) begin
            ft_data_i = 16'(i);
            cycle();
            if (i == DEPTH - 1) begin
                chk("fill.txe_full", 32'(ft_txe), 32'd1);
                chk("fill.no_overflow_yet", 32'(err_overflow), 32'd0);
            end
        end
        chk("fill.overflow", 32'(err_overflow), 32'd1);
        idle();
        host_rx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain.word%0d", i), 32'(host_rx_data), 32'(i));
            cycle();
            check_all($sformatf("drain%0d", i));
        end
        chk("drain.empty", 32'(host_rx_valid), 32'd0);

        // Contention with a non-empty down FIFO
        do_reset();
        host_tx_valid = 1'b1;
        host_tx_data  = 16'hC0DE;
        cycle();
        idle();
        ft_oe     = 1'b0;
        ft_wr     = 1'b0;
        ft_be_i   = BE_BOTH;
        ft_data_i = 16'h5555;
        cycle();
        chk("cont.flag", 32'(err_contention), 32'd1);
        chk("cont.no_up_push", 32'(host_rx_valid), 32'd0);
        chk("cont.no_pop_without_rd", 32'(ft_rxf), 32'd0);
        ft_rd = 1'b0;
        cycle();
        chk("cont.pop_with_rd", 32'(ft_rxf), 32'd1);
        check_all("cont");

        // Reset in the middle of an 8-word read
        do_reset();
        for (int i = 0; i < 8; i++) begin
            host_tx_valid = 1'b1;
            host_tx_data  = 16'h100 + 16'(i);
            cycle();
        end
        idle();
        ft_oe = 1'b0;
        ft_rd = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        ft_wr = 1'b0;
        rst   = 1'b1;
        cycle();
        chk("midrst.ft_rxf", 32'(ft_rxf), 32'd1);
        chk("midrst.ft_txe", 32'(ft_txe), 32'd0);
        chk("midrst.errs", 32'({err_contention, err_overflow, err_underrun}), 32'd0);
        chk("midrst.host_rx_valid", 32'(host_rx_valid), 32'd0);
        idle();

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 399) == 0);
            host_tx_valid = ($urandom_range(0, 2) != 0);
            host_tx_data  = 16'($urandom);
            host_tx_be    = ($urandom_range(0, 1) != 0) ? BE_BOTH : BE_HI;
            host_rx_ready = ($urandom_range(0, 2) == 0);
            ft_data_i     = 16'($urandom);
            ft_be_i       = 2'($urandom_range(0, 3));
            ft_oe         = ($urandom_range(0, 1) != 0);
            ft_rd         = ($urandom_range(0, 3) == 0);
            ft_wr         = ($urandom_range(0, 2) == 0);
            cycle();
            check_all($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
